// File: rtl/color_matrix_pipe.sv
// 3x3 colour-correction matrix on RGB pixels: input capture, multiply, row sum and
// round/clamp stages feeding an output FIFO, with frame-safe shadow/active coefficients.
module color_matrix_pipe #(
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 32,
  parameter int FRAC_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*PIX_W-1:0]    s_rgb,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic                  bypass,
  input  logic [9*COEF_W-1:0]   comp_matrix,
  input  logic                  matrix_valid,
  output logic                  matrix_pending,
  output logic [3*PIX_W-1:0]    m_rgb,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           sat_count
);

  // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
  // s_ready is a credit check, so the pipeline never stalls and never drops a beat.

  localparam int PW = COEF_W + PIX_W + 1;
  localparam int SW = PW + 2;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 3;
  localparam int MW = 9 * COEF_W;
  localparam logic signed [SW-1:0] RND  = SW'(1) << (FRAC_W - 1);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << PIX_W) - 1);

  function automatic logic [MW-1:0] identity();
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < 9; k += 4) m[k*COEF_W +: COEF_W] = COEF_W'(1) << FRAC_W;
    return m;
  endfunction
  localparam logic [MW-1:0] IDENT = identity();

  logic                     r_ready, r_pending, r_in_frame;
  logic [MW-1:0]            r_active, r_shadow;
  logic                     r_in_v, r_s1_v, r_s2_v, r_s3_v;
  logic [3*PIX_W-1:0]       r_in_rgb, r_s1_rgb, r_s2_rgb, r_s3_rgb;
  logic                     r_in_last, r_s1_last, r_s2_last, r_s3_last;
  logic                     r_in_byp, r_s1_byp, r_s2_byp;
  logic signed [PW-1:0]     r_prod [9];
  logic signed [SW-1:0]     r_sum [3];
  logic [3*PIX_W:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic [15:0]              r_sat;

  logic                     w_accept, w_activate, w_push, w_pop;
  logic [CW-1:0]            w_used;
  logic signed [PW-1:0]     w_prod [9];
  logic signed [SW-1:0]     w_sum [3];
  logic signed [SW-1:0]     w_shift [3];
  logic [2:0]               w_clip;
  logic [3*PIX_W-1:0]       w_calc;
  logic [1:0]               w_nclip, w_sat_inc;
  logic [16:0]              w_sat_sum;

  assign w_used     = r_count + CW'(r_in_v) + CW'(r_s1_v) + CW'(r_s2_v) + CW'(r_s3_v);
  assign s_ready    = r_ready & (w_used < CW'(FIFO_DEPTH));
  assign w_accept   = s_valid & s_ready;
  // Swap coefficients only between frames and on an edge that captures no beat.
  assign w_activate = r_pending & ~r_in_frame & ~w_accept;

  for (genvar k = 0; k < 9; k++) begin : g_mul
    assign w_prod[k] = $signed(PW'($signed(r_active[k*COEF_W +: COEF_W])))
                     * $signed(PW'({1'b0, r_in_rgb[(2-(k%3))*PIX_W +: PIX_W]}));
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign w_sum[r]   = SW'(r_prod[3*r]) + SW'(r_prod[3*r+1]) + SW'(r_prod[3*r+2]);
    assign w_shift[r] = (r_sum[r] + RND) >>> FRAC_W;
    assign w_clip[r]  = w_shift[r][SW-1] | (w_shift[r] > PMAX);
    assign w_calc[(2-r)*PIX_W +: PIX_W] = w_shift[r][SW-1]  ? '0 :
                                          (w_shift[r] > PMAX) ? '1 :
                                          w_shift[r][PIX_W-1:0];
  end

  assign w_nclip   = 2'(w_clip[0]) + 2'(w_clip[1]) + 2'(w_clip[2]);
  assign w_sat_inc = (r_s2_v && !r_s2_byp) ? w_nclip : 2'd0;
  assign w_sat_sum = {1'b0, r_sat} + 17'(w_sat_inc);

  assign w_push = r_s3_v;
  assign w_pop  = (r_count != '0) & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_pending  <= 1'b0;
      r_in_frame <= 1'b0;
      r_active   <= IDENT;
      r_shadow   <= IDENT;
      r_in_v     <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s3_v     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sat      <= '0;
    end else begin
      r_ready <= 1'b1;
      if (matrix_valid) begin
        r_shadow  <= comp_matrix;
        r_pending <= 1'b1;
      end else if (w_activate) begin
        r_pending <= 1'b0;
      end
      if (w_activate) r_active <= r_shadow;
      if (w_accept) r_in_frame <= ~s_last;
      r_in_v <= w_accept;
      r_s1_v <= r_in_v;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_sat   <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_in_rgb  <= s_rgb;
      r_in_last <= s_last;
      r_in_byp  <= bypass;
    end
    for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
    r_s1_rgb  <= r_in_rgb;
    r_s1_last <= r_in_last;
    r_s1_byp  <= r_in_byp;
    for (int r = 0; r < 3; r++) r_sum[r] <= w_sum[r];
    r_s2_rgb  <= r_s1_rgb;
    r_s2_last <= r_s1_last;
    r_s2_byp  <= r_s1_byp;
    r_s3_rgb  <= r_s2_byp ? r_s2_rgb : w_calc;
    r_s3_last <= r_s2_last;
    if (w_push) r_mem[r_wr_ptr] <= {r_s3_last, r_s3_rgb};
  end

  assign m_valid        = (r_count != '0);
  assign m_rgb          = m_valid ? r_mem[r_rd_ptr][3*PIX_W-1:0] : '0;
  assign m_last         = m_valid ? r_mem[r_rd_ptr][3*PIX_W] : 1'b0;
  assign busy           = r_in_v | r_s1_v | r_s2_v | r_s3_v | m_valid;
  assign matrix_pending = r_pending;
  assign sat_count      = r_sat;

endmodule
